// File: rtl/attribute_bank_sequencer.sv
// attribute_bank_sequencer: loads triangle attribute packets into a shadow bank and promotes them once the raster/interpolator pair has drained.
module attribute_bank_sequencer #(
  parameter int ATTRIBUTE_SIZE = 32,
  parameter int NUM_ATTRIBUTES = 9,
  parameter int DRAIN_GUARD    = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     s_cmd_tvalid,
  output logic                                     s_cmd_tready,
  input  logic                                     s_cmd_tlast,
  input  logic [ATTRIBUTE_SIZE-1:0]                s_cmd_tdata,
  input  logic                                     raster_busy,
  input  logic                                     pixel_in_pipeline,
  output logic                                     raster_start,
  output logic [NUM_ATTRIBUTES*ATTRIBUTE_SIZE-1:0] attr_active,
  output logic                                     cmd_error,
  output logic                                     seq_busy
);
  localparam int IW = $clog2(NUM_ATTRIBUTES);
  typedef enum logic {L_RECV, L_DISCARD} load_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_RASTER, S_DRAIN, S_SWAP, S_LAUNCH} state_t;
  load_t                                r_load;
  state_t                               r_state;
  logic [IW-1:0]                        r_index;
  logic [NUM_ATTRIBUTES*ATTRIBUTE_SIZE-1:0] r_shadow;
  logic                                 r_shadow_full;
  logic                                 r_error;
  logic                                 r_start;
  logic [3:0]                           r_cnt;
  logic                                 w_xfer;
  logic                                 w_last_idx;
  assign s_cmd_tready = !r_shadow_full && !reset;
  assign w_xfer       = s_cmd_tvalid && s_cmd_tready;
  assign w_last_idx   = r_index == IW'(NUM_ATTRIBUTES-1);
  assign raster_start = r_start;
  assign cmd_error    = r_error;
  assign seq_busy     = (r_index != '0) || r_load == L_DISCARD || r_shadow_full || r_state != S_IDLE;
  // Tready is low while the shadow is full, so the swap clear never meets a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load        <= L_RECV;
      r_index       <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (r_state == S_SWAP) r_shadow_full <= 1'b0;
      if (w_xfer) begin
        if (r_load == L_DISCARD) begin
          if (s_cmd_tlast) r_load <= L_RECV;
        end else begin
          r_shadow[r_index*ATTRIBUTE_SIZE +: ATTRIBUTE_SIZE] <= s_cmd_tdata;
          r_index <= (w_last_idx || s_cmd_tlast) ? '0 : r_index + 1'b1;
          if (s_cmd_tlast && w_last_idx) r_shadow_full <= 1'b1;
          if (s_cmd_tlast != w_last_idx) r_error <= 1'b1;
          if (!s_cmd_tlast && w_last_idx) r_load <= L_DISCARD;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      attr_active <= '0;
    end else begin
      case (r_state)
        S_IDLE:        if (r_shadow_full) r_state <= S_WAIT_RASTER;
        S_WAIT_RASTER: if (!raster_busy) begin
          r_state <= S_DRAIN;
          r_cnt   <= '0;
        end
        S_DRAIN: begin
          if (pixel_in_pipeline) r_cnt <= '0;
          else if (raster_busy) r_state <= S_WAIT_RASTER;
          else if (r_cnt == 4'(DRAIN_GUARD-1)) r_state <= S_SWAP;
          else r_cnt <= r_cnt + 1'b1;
        end
        S_SWAP: begin
          attr_active <= r_shadow;
          r_start     <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_attribute_bank_sequencer.sv
// tb_attribute_bank_sequencer: directed scenarios for the attribute bank sequencer.
module tb_attribute_bank_sequencer;
  logic         clk = 0;
  logic         reset = 1;
  logic         s_cmd_tvalid = 0;
  logic         s_cmd_tready;
  logic         s_cmd_tlast = 0;
  logic [31:0]  s_cmd_tdata = 0;
  logic         raster_busy = 0;
  logic         pixel_in_pipeline = 0;
  logic         raster_start;
  logic [287:0] attr_active;
  logic         cmd_error;
  logic         seq_busy;
  int total = 0;
  int bad = 0;

  attribute_bank_sequencer dut (
    .clk(clk), .reset(reset), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_cmd_tlast(s_cmd_tlast), .s_cmd_tdata(s_cmd_tdata), .raster_busy(raster_busy),
    .pixel_in_pipeline(pixel_in_pipeline), .raster_start(raster_start),
    .attr_active(attr_active), .cmd_error(cmd_error), .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] bank(input logic [31:0] b);
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = b + i;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1;
    @(negedge clk);
    @(negedge clk) reset = 0;
  endtask

  // Drives n words at negedges; returns at the negedge after the tlast edge.
  task automatic send(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int waitc = 0;
      s_cmd_tvalid = 1;
      s_cmd_tdata  = base + i;
      s_cmd_tlast  = (i == n - 1);
      while (!s_cmd_tready && waitc < 200) begin
        @(negedge clk);
        waitc++;
      end
      total++;
      if (!s_cmd_tready) begin
        $display("FAIL send_timeout word=%0d tready=%b required 1", i, s_cmd_tready);
        bad++;
      end
      @(negedge clk);
    end
    s_cmd_tvalid = 0;
    s_cmd_tlast  = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (raster_start !== 1'b0) begin $display("FAIL reset_start got=%b exp=0", raster_start); bad++; end
    total++; if (attr_active !== '0) begin $display("FAIL reset_attr got=%h exp=0", attr_active); bad++; end
    total++; if (cmd_error !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", cmd_error); bad++; end
    total++; if (seq_busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", seq_busy); bad++; end
    total++; if (s_cmd_tready !== 1'b0) begin $display("FAIL reset_tready got=%b exp=0", s_cmd_tready); bad++; end
    @(negedge clk) reset = 0;
    #1;
    total++; if (s_cmd_tready !== 1'b1) begin $display("FAIL release_tready got=%b exp=1", s_cmd_tready); bad++; end
  endtask

  task automatic test_clean();
    send(32'h3F80_0000, 9);
    total++; if (seq_busy !== 1'b1) begin $display("FAIL clean_seqbusy got=%b exp=1", seq_busy); bad++; end
    total++; if (s_cmd_tready !== 1'b0) begin $display("FAIL clean_tready got=%b exp=0", s_cmd_tready); bad++; end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== (k == 5)) begin
        $display("FAIL clean_start k=%0d got=%b exp=%b", k, raster_start, k == 5); bad++;
      end
      if (k == 4) begin
        total++; if (attr_active !== '0) begin $display("FAIL clean_preswap got=%h exp=0", attr_active); bad++; end
      end
    end
    total++; if (attr_active !== bank(32'h3F80_0000)) begin $display("FAIL clean_attr got=%h exp=%h", attr_active, bank(32'h3F80_0000)); bad++; end
    total++; if (seq_busy !== 1'b0) begin $display("FAIL clean_idle got=%b exp=0", seq_busy); bad++; end
  endtask

  task automatic test_drain_hold();
    pixel_in_pipeline = 1;
    send(32'h0000_0100, 9);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== 1'b0 || attr_active !== bank(32'h3F80_0000)) begin
        $display("FAIL drain_hold k=%0d start=%b attr=%h exp_attr=%h", k, raster_start, attr_active, bank(32'h3F80_0000)); bad++;
      end
    end
    pixel_in_pipeline = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== (k == 3)) begin
        $display("FAIL drain_start k=%0d got=%b exp=%b", k, raster_start, k == 3); bad++;
      end
      if (k == 2) begin
        total++; if (attr_active !== bank(32'h3F80_0000)) begin $display("FAIL drain_preswap got=%h exp=%h", attr_active, bank(32'h3F80_0000)); bad++; end
      end
    end
    total++; if (attr_active !== bank(32'h100)) begin $display("FAIL drain_attr got=%h exp=%h", attr_active, bank(32'h100)); bad++; end
  endtask

  task automatic test_back_to_back();
    raster_busy = 1;
    send(32'h0000_0200, 9);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (s_cmd_tready !== 1'b0 || raster_start !== 1'b0) begin
        $display("FAIL b2b_hold k=%0d tready=%b start=%b exp 0 0", k, s_cmd_tready, raster_start); bad++;
      end
    end
    raster_busy = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== (k == 4) || s_cmd_tready !== (k == 4)) begin
        $display("FAIL b2b_swap k=%0d start=%b tready=%b exp=%b", k, raster_start, s_cmd_tready, k == 4); bad++;
      end
    end
    raster_busy = 1;
    total++; if (attr_active !== bank(32'h200)) begin $display("FAIL b2b_attr_a got=%h exp=%h", attr_active, bank(32'h200)); bad++; end
    send(32'h0000_0300, 9);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== 1'b0 || attr_active !== bank(32'h200)) begin
        $display("FAIL b2b_busy k=%0d start=%b attr=%h", k, raster_start, attr_active); bad++;
      end
    end
    raster_busy = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (raster_start !== (k == 4)) begin $display("FAIL b2b_start_b k=%0d got=%b exp=%b", k, raster_start, k == 4); bad++; end
    end
    total++; if (attr_active !== bank(32'h300)) begin $display("FAIL b2b_attr_b got=%h exp=%h", attr_active, bank(32'h300)); bad++; end
  endtask

  task automatic test_short();
    @(negedge clk);
    send(32'h0000_0AA0, 5);
    total++; if (cmd_error !== 1'b1) begin $display("FAIL short_err got=%b exp=1", cmd_error); bad++; end
    total++; if (seq_busy !== 1'b0) begin $display("FAIL short_seqbusy got=%b exp=0", seq_busy); bad++; end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (raster_start !== 1'b0) begin $display("FAIL short_start k=%0d got=%b exp=0", k, raster_start); bad++; end
    end
    send(32'h0000_0400, 9);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++; if (raster_start !== (k == 5)) begin $display("FAIL short_next k=%0d got=%b exp=%b", k, raster_start, k == 5); bad++; end
    end
    total++; if (attr_active !== bank(32'h400)) begin $display("FAIL short_attr got=%h exp=%h", attr_active, bank(32'h400)); bad++; end
    total++; if (cmd_error !== 1'b1) begin $display("FAIL short_sticky got=%b exp=1", cmd_error); bad++; end
  endtask

  task automatic test_long();
    do_reset();
    total++; if (cmd_error !== 1'b0) begin $display("FAIL long_clr got=%b exp=0", cmd_error); bad++; end
    send(32'h0000_0500, 12);
    total++; if (cmd_error !== 1'b1) begin $display("FAIL long_err got=%b exp=1", cmd_error); bad++; end
    total++; if (seq_busy !== 1'b0 || s_cmd_tready !== 1'b1) begin $display("FAIL long_state seq_busy=%b tready=%b exp 0 1", seq_busy, s_cmd_tready); bad++; end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (raster_start !== 1'b0 || attr_active !== '0) begin $display("FAIL long_nostart k=%0d start=%b attr=%h", k, raster_start, attr_active); bad++; end
    end
  endtask

  task automatic test_async_reset();
    send(32'h0000_0600, 9);
    repeat (6) @(negedge clk);
    total++; if (attr_active !== bank(32'h600)) begin $display("FAIL ar_load got=%h exp=%h", attr_active, bank(32'h600)); bad++; end
    pixel_in_pipeline = 1;
    send(32'h0000_0700, 9);
    repeat (5) @(negedge clk);
    #2 reset = 1;
    #1;
    total++; if (attr_active !== '0) begin $display("FAIL ar_attr got=%h exp=0", attr_active); bad++; end
    total++; if (seq_busy !== 1'b0 || raster_start !== 1'b0) begin $display("FAIL ar_busy seq_busy=%b start=%b exp 0 0", seq_busy, raster_start); bad++; end
    @(negedge clk) reset = 0;
    pixel_in_pipeline = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (raster_start !== 1'b0 || attr_active !== '0) begin $display("FAIL ar_after k=%0d start=%b attr=%h", k, raster_start, attr_active); bad++; end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_drain_hold();
    test_back_to_back();
    test_short();
    test_long();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/attribute_bank_sequencer.md
Name: attribute_bank_sequencer

Overview:
- Per-triangle configuration controller for the attribute interpolator.
- Receives the 9 triangle attribute words (tex_s … depth_w_inc_y) as a 32-bit word stream into a shadow bank.
- Promotes the shadow bank to the active bank only when the rasterizer is idle and the interpolator pipeline has drained, then issues a one-cycle rasterizer start pulse.
- Sits between the command parser and the rasterizer/interpolator pair, so attributes never change under in-flight pixels.

Parameters:
- ATTRIBUTE_SIZE, 32, width of one attribute word.
- NUM_ATTRIBUTES, 9, words per triangle packet; fixed order tex_s, tex_t, tex_s_inc_x, tex_t_inc_x, tex_s_inc_y, tex_t_inc_y, depth_w, depth_w_inc_x, depth_w_inc_y.
- DRAIN_GUARD, 2, consecutive cycles pixel_in_pipeline must read 0 before a swap (covers its registered lag); legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_cmd_tvalid  in  1  attribute word valid.
- s_cmd_tready  out  1  attribute word accepted.
- s_cmd_tlast  in  1  last word of the triangle packet.
- s_cmd_tdata  in  ATTRIBUTE_SIZE  attribute word.
- raster_busy  in  1  rasterizer is walking a triangle.
- pixel_in_pipeline  in  1  interpolator holds pixels (pixelInPipeline).
- raster_start  out  1  one-cycle pulse: rasterizer begins the new triangle.
- attr_active  out  NUM_ATTRIBUTES*ATTRIBUTE_SIZE  active bank; word i at [i*ATTRIBUTE_SIZE +: ATTRIBUTE_SIZE], wired to the interpolator attribute inputs.
- cmd_error  out  1  sticky: malformed packet seen.
- seq_busy  out  1  packet loading, shadow pending, or swap in progress.

Behaviour:
- Reset (async, immediate): attr_active=0, shadow bank=0, shadow_full=0, word index=0, loader=L_RECV, main FSM=S_IDLE, raster_start=0, cmd_error=0, DRAIN_GUARD counter=0.
- s_cmd_tready = !shadow_full && !reset. A word transfers on tvalid && tready at the clk edge.
- Loader L_RECV:
  - Each accepted word is written to shadow[index], then index++.
  - tlast with index==NUM_ATTRIBUTES-1: shadow_full<=1, index<=0.
  - tlast with index<NUM_ATTRIBUTES-1 (short packet): cmd_error<=1, index<=0, shadow_full stays 0, partial data discarded.
  - Word at index==NUM_ATTRIBUTES-1 without tlast (long packet): cmd_error<=1, index<=0, go to L_DISCARD.
- Loader L_DISCARD: accept and drop words, tready=1; on tlast go to L_RECV.
- Main FSM:
  - S_IDLE: shadow_full -> S_WAIT_RASTER.
  - S_WAIT_RASTER: !raster_busy -> S_DRAIN, counter<=0.
  - S_DRAIN:
    - pixel_in_pipeline=1: counter<=0.
    - raster_busy=1: back to S_WAIT_RASTER.
    - Otherwise counter++; when counter reaches DRAIN_GUARD-1 with pixel_in_pipeline=0 -> S_SWAP.
  - S_SWAP: attr_active<=shadow, shadow_full<=0, raster_start<=1 -> S_LAUNCH.
  - S_LAUNCH: raster_start<=0 -> S_IDLE. raster_start is therefore high for exactly one cycle, the cycle after the swap edge.
- Minimum latency, tlast accept edge to raster_start high, when idle and drained: S_IDLE (1) + S_WAIT_RASTER (1) + S_DRAIN (DRAIN_GUARD) + S_SWAP edge = DRAIN_GUARD+3 cycles; 5 at the default.
- The rasterizer contract is raster_busy=1 no later than the cycle after raster_start. The next shadow needs ≥9 cycles to load, so a stale busy=0 is never sampled.
- Simultaneous events:
  - The shadow clear in S_SWAP and a new word arriving on the same edge cannot collide, because tready=0 while shadow_full.
  - tready rises the cycle after the swap.
- attr_active is stable at all times except the single S_SWAP edge.
- seq_busy = (index!=0) || loader==L_DISCARD || shadow_full || state!=S_IDLE.
- cmd_error clears only on reset.
- Reset mid-packet or mid-drain: everything returns to reset values and no raster_start is issued; the upstream source must restart the packet.

Test Plan:
- Clean load, idle system: words 0x3F800000+i (i=0..8), tlast on word 8, busy=0, pip=0 -> raster_start pulses 5 cycles after the tlast edge, width 1; attr_active word i = 0x3F800000+i.
- Drain hold: pip=1 for 20 cycles after the packet, then 0 -> no swap while pip=1; swap exactly DRAIN_GUARD cycles after pip falls; attr_active unchanged before that.
- Back-pressure: second packet sent right after the first while raster_busy=1 -> tready=0 after the 9th word until the swap; the second packet is accepted only after the first raster_start and promoted only after busy falls.
- Short packet: tlast on word 4 -> cmd_error=1, no raster_start; the following clean packet still loads and launches normally.
- Long packet: 12 words, tlast on word 11 -> cmd_error=1, words 9..11 dropped, shadow_full=0, no raster_start.
- Async reset asserted in S_DRAIN, between clock edges -> outputs cleared immediately; attr_active=0, no raster_start after release.
